// File: rtl/mc6502_bus_if.sv
// Bus interface unit that turns mc6502 core accesses into a memory req/ack handshake.
// Define MC6502_BUS_IF_TIMEOUT_EN to abort requests that stay unacknowledged too long.
module mc6502_bus_if #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [7:0]  DB_RESET = 8'h00
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        CORE_REQ,
  input  logic        CORE_WE,
  input  logic        CORE_SYNC,
  input  logic [7:0]  ABL,
  input  logic [7:0]  ABH,
  input  logic [7:0]  DB_OUT,
  output logic [7:0]  DB_IN,
  output logic        RD_VALID,
  output logic        STALL,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic        MEM_SYNC,
  output logic [15:0] MEM_ADDR,
  output logic [7:0]  MEM_WDATA,
  input  logic        MEM_ACK,
  input  logic [7:0]  MEM_RDATA,
  output logic        BUS_ERR
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_sync_q, mem_sync_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic [7:0]  db_in_q, db_in_d;
  logic        rd_valid_q, rd_valid_d;
  logic        bus_err_q, bus_err_d;
  logic        issue;
  logic        timeout_hit;

  assign issue = (state_q == StIdle) && CORE_REQ;

`ifdef MC6502_BUS_IF_TIMEOUT_EN
  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  logic [7:0] wait_cnt_q, wait_cnt_d;

  // Timeout fires in the last permitted unacknowledged WAIT cycle; an ACK there still wins.
  assign timeout_hit = (state_q == StWait) && !MEM_ACK && (wait_cnt_q == WaitLast);

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (issue) begin
      wait_cnt_d = 8'd0;
    end else if ((state_q == StWait) && !MEM_ACK) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      wait_cnt_q <= 8'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  logic [7:0] unused_timeout;

  assign unused_timeout = 8'(TIMEOUT);
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_sync_d  = mem_sync_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    db_in_d     = db_in_q;
    rd_valid_d  = 1'b0;
    bus_err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (CORE_REQ) begin
          state_d     = StWait;
          mem_req_d   = 1'b1;
          mem_we_d    = CORE_WE;
          mem_sync_d  = CORE_SYNC;
          mem_addr_d  = {ABH, ABL};
          mem_wdata_d = DB_OUT;
        end
      end
      StWait: begin
        if (MEM_ACK) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            db_in_d    = MEM_RDATA;
            rd_valid_d = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          if (!mem_we_q) begin
            db_in_d    = 8'hFF;
            rd_valid_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_sync_q  <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
      db_in_q     <= DB_RESET;
      rd_valid_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_sync_q  <= mem_sync_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      db_in_q     <= db_in_d;
      rd_valid_q  <= rd_valid_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // The core advances in the ACK (or timeout) cycle.
  assign STALL = issue || ((state_q == StWait) && !MEM_ACK && !timeout_hit);

  assign DB_IN     = db_in_q;
  assign RD_VALID  = rd_valid_q;
  assign MEM_REQ   = mem_req_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_SYNC  = mem_sync_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;
  assign BUS_ERR   = bus_err_q;

endmodule

// File: tb/tb_mc6502_bus_if.sv
// Directed bench for mc6502_bus_if: a transaction-level model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_mc6502_bus_if;

  localparam int unsigned To    = 4;
  localparam logic [7:0]  DbRst = 8'h00;
`ifdef MC6502_BUS_IF_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        res, core_req, core_we, core_sync, mem_ack;
  logic [7:0]  abl, abh, db_out, mem_rdata;
  logic [7:0]  db_in, mem_wdata;
  logic [15:0] mem_addr;
  logic        rd_valid, stall, mem_req, mem_we, mem_sync, bus_err;

  int n_checks = 0;
  int n_errors = 0;

  mc6502_bus_if #(
    .TIMEOUT (To),
    .DB_RESET(DbRst)
  ) dut (
    .CLK      (clk),
    .RES      (res),
    .CORE_REQ (core_req),
    .CORE_WE  (core_we),
    .CORE_SYNC(core_sync),
    .ABL      (abl),
    .ABH      (abh),
    .DB_OUT   (db_out),
    .DB_IN    (db_in),
    .RD_VALID (rd_valid),
    .STALL    (stall),
    .MEM_REQ  (mem_req),
    .MEM_WE   (mem_we),
    .MEM_SYNC (mem_sync),
    .MEM_ADDR (mem_addr),
    .MEM_WDATA(mem_wdata),
    .MEM_ACK  (mem_ack),
    .MEM_RDATA(mem_rdata),
    .BUS_ERR  (bus_err)
  );

  always #5 clk = ~clk;

  function automatic void chk1(string name, logic act, logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chk8(string name, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chk16(string name, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Transaction view: one outstanding access, the bytes captured for it, and how many
  // cycles memory has let it sit unacknowledged.
  bit          m_valid = 1'b0;
  bit          m_pend, m_we, m_sync, m_rd, m_err;
  int          m_unacked;
  logic [15:0] m_addr;
  logic [7:0]  m_wd, m_last;

  function automatic bit m_gives_up();
    return ToEn && m_pend && (m_unacked == int'(To) - 1);
  endfunction

  always @(posedge clk) begin
    if (res) begin
      m_valid = 1'b1; m_pend = 1'b0; m_we = 1'b0; m_sync = 1'b0; m_unacked = 0;
      m_addr = 16'h0000; m_wd = 8'h00; m_last = DbRst; m_rd = 1'b0; m_err = 1'b0;
    end else if (m_valid) begin
      m_rd  = 1'b0;
      m_err = 1'b0;
      if (!m_pend) begin
        if (core_req) begin
          m_pend = 1'b1; m_unacked = 0; m_addr = {abh, abl}; m_wd = db_out;
          m_we = core_we; m_sync = core_sync;
        end
      end else if (mem_ack) begin
        m_pend = 1'b0;
        if (!m_we) begin m_last = mem_rdata; m_rd = 1'b1; end
      end else if (m_gives_up()) begin
        m_pend = 1'b0; m_err = 1'b1;
        if (!m_we) begin m_last = 8'hFF; m_rd = 1'b1; end
      end else begin
        m_unacked++;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk1 ("cyc_mem_req",   mem_req,   m_pend);
      chk1 ("cyc_mem_we",    mem_we,    m_we);
      chk1 ("cyc_mem_sync",  mem_sync,  m_sync);
      chk16("cyc_mem_addr",  mem_addr,  m_addr);
      chk8 ("cyc_mem_wdata", mem_wdata, m_wd);
      chk8 ("cyc_db_in",     db_in,     m_last);
      chk1 ("cyc_rd_valid",  rd_valid,  m_rd);
      chk1 ("cyc_bus_err",   bus_err,   m_err);
      chk1 ("cyc_stall",     stall,
            m_pend ? (!mem_ack && !m_gives_up()) : core_req);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    res = 1'b1; core_req = 1'b0; core_we = 1'b0; core_sync = 1'b0;
    abl = 8'h00; abh = 8'h00; db_out = 8'h00; mem_ack = 1'b0; mem_rdata = 8'h00;
    tick(); tick();
    chk8("rst_db_in", db_in, 8'h00);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_bus_err", bus_err, 1'b0);
    res = 1'b0;
    #1 chk1("rst_stall", stall, 1'b0);

    // Zero-wait opcode fetch from 1234.
    abh = 8'h12; abl = 8'h34; core_req = 1'b1; core_we = 1'b0; core_sync = 1'b1;
    #1 chk1("rd0_issue_stall", stall, 1'b1);
    tick();
    chk1 ("rd0_req", mem_req, 1'b1);
    chk16("rd0_addr", mem_addr, 16'h1234);
    chk1 ("rd0_sync", mem_sync, 1'b1);
    mem_ack = 1'b1; mem_rdata = 8'hA9;
    #1 chk1("rd0_ack_stall", stall, 1'b0);
    tick();
    chk1("rd0_req_drop", mem_req, 1'b0);
    chk8("rd0_db_in", db_in, 8'hA9);
    chk1("rd0_rd_valid", rd_valid, 1'b1);
    core_req = 1'b0; core_sync = 1'b0; mem_ack = 1'b0;
    tick();
    chk1("rd0_pulse_end", rd_valid, 1'b0);
    chk8("rd0_db_hold", db_in, 8'hA9);

    // Write to 01FF with two unacknowledged WAIT cycles; inputs wiggle during WAIT.
    abh = 8'h01; abl = 8'hFF; db_out = 8'h5A; core_we = 1'b1; core_req = 1'b1;
    tick();
    chk1 ("wr_we", mem_we, 1'b1);
    chk16("wr_addr", mem_addr, 16'h01FF);
    abl = 8'h00; db_out = 8'hC3;
    for (int i = 0; i < 2; i++) begin
      #1 chk1("wr_wait_stall", stall, 1'b1);
      tick();
      chk8 ("wr_wdata_hold", mem_wdata, 8'h5A);
      chk16("wr_addr_hold", mem_addr, 16'h01FF);
      chk1 ("wr_req_hold", mem_req, 1'b1);
    end
    mem_ack = 1'b1;
    #1 chk1("wr_ack_stall", stall, 1'b0);
    tick();
    chk1("wr_req_drop", mem_req, 1'b0);
    chk1("wr_no_rd_valid", rd_valid, 1'b0);
    chk8("wr_db_unchanged", db_in, 8'hA9);
    core_req = 1'b0; core_we = 1'b0; mem_ack = 1'b0;

    // Back-to-back reads FFFC then FFFD; ACK held through the IDLE issue cycle.
    abh = 8'hFF; abl = 8'hFC; core_req = 1'b1;
    tick();
    chk16("b2b_addr0", mem_addr, 16'hFFFC);
    mem_ack = 1'b1; mem_rdata = 8'h00; abl = 8'hFD;
    tick();
    chk8("b2b_db0", db_in, 8'h00);
    chk1("b2b_rv0", rd_valid, 1'b1);
    chk1("b2b_req_gap", mem_req, 1'b0);
    mem_rdata = 8'h77;
    #1 chk1("b2b_issue_stall", stall, 1'b1);
    tick();
    chk1 ("b2b_req1", mem_req, 1'b1);
    chk16("b2b_addr1", mem_addr, 16'hFFFD);
    chk8 ("b2b_idle_ack_ignored", db_in, 8'h00);
    mem_rdata = 8'hE0; core_req = 1'b0;
    tick();
    chk8("b2b_db1", db_in, 8'hE0);
    chk1("b2b_rv1", rd_valid, 1'b1);
    mem_rdata = 8'h55;
    tick();
    chk1("idle_ack_no_rv", rd_valid, 1'b0);
    chk8("idle_ack_db", db_in, 8'hE0);
    mem_ack = 1'b0;

    // Reset during the second WAIT cycle of a read.
    abh = 8'h40; abl = 8'h00; core_req = 1'b1;
    tick(); tick();
    chk1("rstw_req_before", mem_req, 1'b1);
    res = 1'b1;
    tick();
    chk1 ("rstw_req", mem_req, 1'b0);
    chk8 ("rstw_db_in", db_in, DbRst);
    chk16("rstw_addr", mem_addr, 16'h0000);
    res = 1'b0; core_req = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h33;
    tick();
    chk1("rstw_late_ack_rv", rd_valid, 1'b0);
    chk8("rstw_late_ack_db", db_in, 8'h00);
    mem_ack = 1'b0;
    tick();

`ifdef MC6502_BUS_IF_TIMEOUT_EN
    // Read that memory never answers: gives up after four WAIT cycles.
    abh = 8'h20; abl = 8'h00; core_req = 1'b1;
    tick(); tick(); tick(); tick();
    chk1("to_req_w4", mem_req, 1'b1);
    #1 chk1("to_final_stall", stall, 1'b0);
    core_req = 1'b0;
    tick();
    chk1("to_req_drop", mem_req, 1'b0);
    chk1("to_bus_err", bus_err, 1'b1);
    chk8("to_db_ff", db_in, 8'hFF);
    chk1("to_rd_valid", rd_valid, 1'b1);
    tick();
    chk1("to_bus_err_pulse", bus_err, 1'b0);
    // ACK in the would-be timeout cycle completes normally.
    abl = 8'h01; core_req = 1'b1;
    tick(); tick(); tick(); tick();
    mem_ack = 1'b1; mem_rdata = 8'h6B;
    tick();
    chk1("tw_bus_err", bus_err, 1'b0);
    chk8("tw_db_in", db_in, 8'h6B);
    chk1("tw_req_drop", mem_req, 1'b0);
    core_req = 1'b0; mem_ack = 1'b0;
`else
    // Without the timeout, an unanswered request waits indefinitely.
    abh = 8'h20; abl = 8'h00; core_req = 1'b1;
    tick();
    for (int i = 0; i < 22; i++) begin
      tick();
      chk1("nto_req_held", mem_req, 1'b1);
      chk1("nto_bus_err", bus_err, 1'b0);
    end
    mem_ack = 1'b1; mem_rdata = 8'h6B;
    tick();
    chk8("nto_db_in", db_in, 8'h6B);
    core_req = 1'b0; mem_ack = 1'b0;
`endif
    tick(); tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mc6502_bus_if.md
Name: mc6502_bus_if

Overview:
- Bus interface unit between the mc6502 datapath/control pair and external memory.
- Takes the datapath's registered address bytes (ABL/ABH) and write data (DB_OUT), and runs a req/ack transaction on the memory side.
- Returns read data as the datapath's DB_IN.
- Asserts STALL so the control unit freezes its cycle sequencing while memory has wait states.

Parameters:
- TIMEOUT, 16: max cycles MEM_REQ may stay high without MEM_ACK (used only with the optional feature); range 2..255.
- DB_RESET, 8'h00: reset value of DB_IN and the last-read holding register.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RES  input  1  reset; synchronous, active-high.
- CORE_REQ  input  1  core requests an access this cycle; held high until STALL is low.
- CORE_WE  input  1  1=write, 0=read; stable while CORE_REQ is high.
- CORE_SYNC  input  1  access is an opcode fetch; forwarded to MEM_SYNC.
- ABL  input  8  address low byte.
- ABH  input  8  address high byte.
- DB_OUT  input  8  write data from datapath.
- DB_IN  output  8  read data to datapath (registered).
- RD_VALID  output  1  one-cycle pulse; DB_IN updated this cycle.
- STALL  output  1  core must hold its state and request.
- MEM_REQ  output  1  memory request (registered).
- MEM_WE  output  1  memory write enable (registered).
- MEM_SYNC  output  1  opcode-fetch qualifier (registered).
- MEM_ADDR  output  16  {ABH,ABL} captured at issue (registered).
- MEM_WDATA  output  8  write data captured at issue (registered).
- MEM_ACK  input  1  memory completes the access this cycle.
- MEM_RDATA  input  8  read data; valid when MEM_ACK=1 and MEM_WE=0.
- BUS_ERR  output  1  timeout pulse; tied 0 when the optional feature is off.

Behaviour:
- Reset (RES=1 at posedge): state=IDLE; MEM_REQ/MEM_WE/MEM_SYNC=0; MEM_ADDR=16'h0000; MEM_WDATA=8'h00; DB_IN=DB_RESET; RD_VALID=0; BUS_ERR=0.
- Reset mid-transaction: MEM_REQ drops on that edge and the pending access is abandoned. Memory must tolerate REQ withdrawal.
- States: IDLE and WAIT.
- IDLE:
  - If CORE_REQ=1: latch {ABH,ABL}, DB_OUT, CORE_WE and CORE_SYNC into the MEM_* registers; set MEM_REQ=1; go to WAIT.
  - MEM_ACK is ignored in IDLE.
- WAIT, MEM_ACK=1:
  - MEM_REQ<=0; go to IDLE.
  - If read: DB_IN<=MEM_RDATA and RD_VALID<=1 for one cycle.
  - If write: DB_IN is unchanged and RD_VALID stays 0.
- WAIT, MEM_ACK=0: hold all MEM_* outputs stable.
- STALL (combinational) = (IDLE && CORE_REQ) || (WAIT && !MEM_ACK).
  - The core advances in the ACK cycle.
  - Read data is visible on DB_IN from the following cycle, aligned with RD_VALID.
- Latency:
  - Zero-wait memory (ACK in the first WAIT cycle): 2 cycles per access, 1 stall cycle.
  - Each extra wait cycle adds 1 stall cycle.
- Back-to-back: a new CORE_REQ in the cycle after ACK issues immediately from IDLE. There is no idle bubble beyond the issue cycle.
- Address/data inputs are sampled only at issue. Changes during WAIT have no effect.
- MEM_ADDR carries no wrap or arithmetic: it is a straight concatenation {ABH,ABL}.
- DB_IN holds its last read value indefinitely (datapath DL/IR may re-sample it).

Optional Feature:
- Macro: MC6502_BUS_IF_TIMEOUT_EN.
- Enabled:
  - An 8-bit wait counter clears at issue and increments each WAIT cycle with MEM_ACK=0.
  - When it reaches TIMEOUT-1 without ACK: MEM_REQ<=0, go to IDLE, DB_IN<=8'hFF for reads (RD_VALID pulses), BUS_ERR pulses for one cycle.
  - STALL is low in that final cycle.
  - An ACK arriving in the same cycle as the timeout wins: normal completion, BUS_ERR=0.
- Disabled: no counter; WAIT lasts indefinitely; BUS_ERR constant 0.

Test Plan:
- Reset then idle: RES=1 for 2 cycles -> DB_IN=8'h00, MEM_REQ=0, STALL=0, BUS_ERR=0.
- Zero-wait read: ABH=8'h12, ABL=8'h34, CORE_REQ=1, CORE_WE=0, ACK in the first WAIT cycle with MEM_RDATA=8'hA9 -> MEM_ADDR=16'h1234, MEM_REQ high for exactly 1 cycle, STALL high 1 cycle, next cycle DB_IN=8'hA9 and RD_VALID=1.
- Wait-state write: CORE_WE=1, DB_OUT=8'h5A, addr 16'h01FF, ACK after 3 WAIT cycles -> MEM_WE=1, MEM_WDATA=8'h5A held 3 cycles, STALL high 3 cycles, DB_IN unchanged, RD_VALID=0.
- Back-to-back: read 16'hFFFC (data 8'h00), then read 16'hFFFD (data 8'hE0) with zero-wait ACK -> MEM_REQ pattern 1,0,1 and DB_IN sequence 8'h00 then 8'hE0; an ACK injected while IDLE is ignored.
- Reset mid-WAIT: RES=1 during the 2nd WAIT cycle -> MEM_REQ=0 after that edge, state IDLE, DB_IN=DB_RESET; a later ACK produces no RD_VALID.
- Timeout (macro defined, TIMEOUT=4): read with no ACK -> after 4 cycles MEM_REQ=0, BUS_ERR=1 for one cycle, DB_IN=8'hFF; macro undefined -> MEM_REQ stays high for 20+ cycles.
